// File: rtl/spi_master_duplex_pkg.sv
// Shared types for the full-duplex SPI master: FSM states, SPI mode encodings
// and helpers to split a mode into its clock polarity and phase.
package spi_master_duplex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    // {CPOL,CPHA}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    function automatic logic mode_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_master_duplex_clk_tick.sv
// Half-period tick generator: emits a one-cycle enable every CLK_DIV clk
// cycles while enabled; the count restarts from zero whenever cleared.
module spi_clk_tick
    import spi_master_duplex_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNTW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(CLK_DIV - 1);

    logic [CNTW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, otherwise wrap at the end of a half-period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master with runtime mode, bit order, transfer length and
// chip-select selection. Sequence: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE,
// each phase measured in CLK_DIV-cycle half-periods from spi_clk_tick.
module spi_master_duplex
    import spi_master_duplex_pkg::*;
#(
    parameter int  CLK_DIV  = 4,
    parameter int  MAX_BITS = 32,
    parameter int  NUM_CS   = 4,
    localparam int DW       = $clog2(MAX_BITS + 1),
    localparam int CW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_start,
    input  logic [1:0]          spi_mode,
    input  logic                spi_msb_first,
    input  logic [CW-1:0]       spi_cs_sel,
    input  logic [DW-1:0]       spi_data_depth,
    input  logic [MAX_BITS-1:0] spi_data_tx,
    output logic                spi_ready,
    output logic [MAX_BITS-1:0] spi_data_rx,
    output logic                spi_rx_valid,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [NUM_CS-1:0]   spi_cs_n
);

    localparam logic [DW-1:0] MAXD = DW'(MAX_BITS);

    spi_state_e          state_q, state_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                msb_q, msb_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic [DW:0]         hcnt_q, hcnt_d;
    logic [MAX_BITS-1:0] tx_q, tx_d;
    logic [MAX_BITS-1:0] rx_q, rx_d;
    logic [MAX_BITS-1:0] data_rx_q, data_rx_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                rx_valid_q, rx_valid_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;

    logic                tick;
    logic                accept;
    logic [DW-1:0]       depth_clamped;
    logic [MAX_BITS-1:0] tx_aligned;
    logic [MAX_BITS-1:0] tx_shifted;
    logic                leading;
    logic                last_half;
    logic                do_sample;
    logic                do_shift;

    // The counter is held clear in IDLE, so it restarts from zero on accept.
    spi_clk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == ST_IDLE),
        .en_i  (state_q != ST_IDLE),
        .tick_o(tick)
    );

    // Request decode and TX alignment: MSB-first pre-shifts so the first bit sits at the top.
    always_comb begin
        depth_clamped = (spi_data_depth > MAXD) ? MAXD : spi_data_depth;
        accept        = (state_q == ST_IDLE) && spi_start && (spi_data_depth != '0)
                        && (int'(spi_cs_sel) < NUM_CS);
        tx_aligned    = spi_msb_first ? (spi_data_tx << (MAXD - depth_clamped)) : spi_data_tx;
        tx_shifted    = msb_q ? (tx_q << 1) : (tx_q >> 1);
    end

    // Edge classification within XFER: even half-periods end on a leading edge.
    // CPHA=1 keeps the first bit across the first leading edge since it is already on MOSI.
    always_comb begin
        leading   = ~hcnt_q[0];
        last_half = (hcnt_q == ({depth_q, 1'b0} - 1'b1));
        do_sample = tick && (state_q == ST_XFER) && (cpha_q ? !leading : leading);
        do_shift  = tick && (state_q == ST_XFER)
                    && (cpha_q ? (leading && (hcnt_q != '0)) : (!leading && !last_half));
    end

    // Next-state and datapath updates for the transfer sequence.
    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        msb_d      = msb_q;
        depth_d    = depth_q;
        hcnt_d     = hcnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_rx_d  = data_rx_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        cs_n_d     = cs_n_q;

        if (do_sample) begin
            rx_d = msb_q ? MAX_BITS'({rx_q, spi_miso}) : MAX_BITS'({spi_miso, rx_q} >> 1);
        end
        if (do_shift) begin
            tx_d   = tx_shifted;
            mosi_d = msb_q ? tx_shifted[MAX_BITS-1] : tx_shifted[0];
        end

        case (state_q)
            ST_IDLE: begin
                sclk_d = mode_cpol(spi_mode);
                if (accept) begin
                    state_d = ST_SETUP;
                    cpol_d  = mode_cpol(spi_mode);
                    cpha_d  = mode_cpha(spi_mode);
                    msb_d   = spi_msb_first;
                    depth_d = depth_clamped;
                    hcnt_d  = '0;
                    tx_d    = tx_aligned;
                    mosi_d  = spi_msb_first ? tx_aligned[MAX_BITS-1] : tx_aligned[0];
                    rx_d    = '0;
                    cs_n_d  = ~(NUM_CS'(1) << spi_cs_sel);
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    hcnt_d = hcnt_q + 1'b1;
                    if (last_half) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d    = ST_GAP;
                    cs_n_d     = '1;
                    rx_valid_d = 1'b1;
                    // LSB-first fills from the top, so right-align it here.
                    data_rx_d  = msb_q ? rx_q : (rx_q >> (MAXD - depth_q));
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            msb_q      <= 1'b0;
            depth_q    <= '0;
            hcnt_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_rx_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            cs_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            msb_q      <= msb_d;
            depth_q    <= depth_d;
            hcnt_q     <= hcnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_rx_q  <= data_rx_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign spi_ready    = (state_q == ST_IDLE);
    assign spi_data_rx  = data_rx_q;
    assign spi_rx_valid = rx_valid_q;
    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_duplex.sv
// Directed bench for spi_master_duplex with a behavioural SPI slave and an
// RX scoreboard (expected words queued at start, popped on spi_rx_valid).
module tb_spi_master_duplex;
    import spi_master_duplex_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int MAX_BITS = 32;
    localparam int NUM_CS   = 3;
    localparam int DW       = $clog2(MAX_BITS + 1);
    localparam int CW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                spi_start = 1'b0;
    logic [1:0]          spi_mode = 2'b00;
    logic                spi_msb_first = 1'b1;
    logic [CW-1:0]       spi_cs_sel = '0;
    logic [DW-1:0]       spi_data_depth = '0;
    logic [MAX_BITS-1:0] spi_data_tx = '0;
    logic                spi_ready;
    logic [MAX_BITS-1:0] spi_data_rx;
    logic                spi_rx_valid;
    logic                spi_sclk;
    logic                spi_mosi;
    logic                spi_miso;
    logic [NUM_CS-1:0]   spi_cs_n;

    spi_master_duplex #(
        .CLK_DIV (CLK_DIV),
        .MAX_BITS(MAX_BITS),
        .NUM_CS  (NUM_CS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_start     (spi_start),
        .spi_mode      (spi_mode),
        .spi_msb_first (spi_msb_first),
        .spi_cs_sel    (spi_cs_sel),
        .spi_data_depth(spi_data_depth),
        .spi_data_tx   (spi_data_tx),
        .spi_ready     (spi_ready),
        .spi_data_rx   (spi_data_rx),
        .spi_rx_valid  (spi_rx_valid),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_cs_n      (spi_cs_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int sclk_tog = 0;
    int cs0_low = 0;
    int rxv_cnt = 0;
    int rxv_cyc = -1;
    int ready_cyc = -1;
    logic [31:0] exp_q[$];
    logic        mosi_bits[$];

    // Behavioural slave: drives sl_word in the configured order, records MOSI.
    logic        use_loop = 1'b1;
    logic [31:0] sl_word = '0;
    int          sl_depth = 1;
    logic        sl_msb = 1'b1;
    logic        sl_cpol = 1'b0;
    logic        sl_cpha = 1'b0;
    int          sl_idx = 0;
    logic        miso_model = 1'b0;
    wire         cs_idle = &spi_cs_n;

    assign spi_miso = use_loop ? spi_mosi : miso_model;

    function automatic logic sl_bit(input int k);
        if (k >= sl_depth) return 1'b0;
        return sl_msb ? sl_word[sl_depth-1-k] : sl_word[k];
    endfunction

    always @(negedge cs_idle) begin
        sl_idx = 0;
        if (!sl_cpha) miso_model = sl_bit(0);
    end

    always @(spi_sclk) begin
        sclk_tog++;
        if (!cs_idle) begin
            if (spi_sclk === 1'b1) rise_cnt++;
            if (sl_cpha ? (spi_sclk == sl_cpol) : (spi_sclk != sl_cpol)) mosi_bits.push_back(spi_mosi);
            if (sl_cpha && (spi_sclk != sl_cpol)) begin
                miso_model = sl_bit(sl_idx);
                sl_idx++;
            end else if (!sl_cpha && (spi_sclk == sl_cpol)) begin
                sl_idx++;
                miso_model = sl_bit(sl_idx);
            end
        end
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and CS-low monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (spi_cs_n[0] === 1'b0) cs0_low++;
        if (spi_rx_valid === 1'b1) begin
            rxv_cnt++;
            rxv_cyc = cyc;
            if (exp_q.size() == 0) chk("rx_unexpected", 64'd1, 64'd0);
            else chk("rx_data", {32'd0, spi_data_rx}, {32'd0, exp_q.pop_front()});
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 3000; i++) begin
            if (spi_ready === 1'b1) break;
            @(negedge clk);
        end
        ready_cyc = cyc;
        chk("ready_timeout", spi_ready, 1);
    endtask

    task automatic xfer(input logic [1:0] mode, input logic msb, input int cs, input int depth,
                        input logic [31:0] tx, input logic loop, input logic [31:0] sword,
                        input logic [31:0] exp, input logic poke);
        int deff;
        int sc;
        logic [31:0] seq_exp;
        logic [31:0] seq_got;
        logic [NUM_CS-1:0] cs_exp;
        deff = (depth > MAX_BITS) ? MAX_BITS : depth;
        @(negedge clk);
        spi_mode = mode; spi_msb_first = msb; spi_cs_sel = cs[CW-1:0];
        spi_data_depth = depth[DW-1:0]; spi_data_tx = tx;
        use_loop = loop; sl_word = sword; sl_depth = deff; sl_msb = msb;
        sl_cpol = mode[1]; sl_cpha = mode[0];
        @(negedge clk);
        chk("sclk_idle", spi_sclk, mode[1]);
        exp_q.push_back(exp);
        rise_cnt = 0; cs0_low = 0; rxv_cnt = 0; rxv_cyc = -1; mosi_bits.delete();
        spi_start = 1'b1;
        sc = cyc;
        @(negedge clk);
        spi_start = 1'b0;
        chk("busy", spi_ready, 0);
        cs_exp = ~(NUM_CS'(1) << cs);
        chk("cs_sel", spi_cs_n, cs_exp);
        if (poke) begin
            repeat (100) @(negedge clk);
            spi_data_tx = '0; spi_data_depth = 6'd8; spi_start = 1'b1;
            @(negedge clk);
            spi_start = 1'b0;
            chk("poke_busy", spi_ready, 0);
        end
        wait_ready();
        chk("ready_time", ready_cyc - sc, 1 + CLK_DIV * (2 * deff + 3));
        chk("rxv_count", rxv_cnt, 1);
        chk("rxv_time", rxv_cyc - sc, 1 + CLK_DIV * (2 * deff + 2));
        chk("sclk_rises", rise_cnt, deff);
        if (cs == 0) chk("cs_low_time", cs0_low, CLK_DIV * (2 * deff + 2));
        seq_exp = '0;
        seq_got = '0;
        for (int k = 0; k < deff; k++) seq_exp = {seq_exp[30:0], msb ? tx[deff-1-k] : tx[k]};
        for (int k = 0; k < mosi_bits.size(); k++) seq_got = {seq_got[30:0], mosi_bits[k]};
        chk("mosi_count", mosi_bits.size(), deff);
        chk("mosi_seq", seq_got, seq_exp);
    endtask

    task automatic reject(input int depth, input int cs);
        int bad;
        bad = 0;
        @(negedge clk);
        spi_mode = MODE0; spi_data_depth = depth[DW-1:0]; spi_cs_sel = cs[CW-1:0];
        spi_data_tx = 32'hFFFF_FFFF;
        @(negedge clk);
        sclk_tog = 0; rxv_cnt = 0;
        spi_start = 1'b1;
        @(negedge clk);
        spi_start = 1'b0;
        repeat (40) begin
            if (spi_ready !== 1'b1 || spi_cs_n !== '1) bad++;
            @(negedge clk);
        end
        chk("rej_ready_cs", bad, 0);
        chk("rej_sclk_static", sclk_tog, 0);
        chk("rej_no_rxv", rxv_cnt, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", spi_ready, 1);
        chk("rst_rx_valid", spi_rx_valid, 0);
        chk("rst_data_rx", spi_data_rx, 0);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_cs_n", spi_cs_n, 3'b111);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        xfer(MODE0, 1'b1, 0, 16, 32'h0000_AABB, 1'b1, 32'h0, 32'h0000_AABB, 1'b0);
        xfer(MODE3, 1'b0, 1, 8, 32'hFFFF_FF81, 1'b0, 32'h81, 32'h0000_0081, 1'b0);
        xfer(MODE1, 1'b1, 2, 8, 32'h0000_00C3, 1'b0, 32'h5A, 32'h0000_005A, 1'b0);
        xfer(MODE2, 1'b0, 1, 8, 32'h0000_003C, 1'b0, 32'h5A, 32'h0000_005A, 1'b0);
        xfer(MODE1, 1'b1, 0, 1, 32'h0000_0001, 1'b1, 32'h0, 32'h0000_0001, 1'b0);

        reject(0, 0);
        reject(8, NUM_CS);

        xfer(MODE0, 1'b1, 2, 40, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b1);

        // Reset in the middle of bit 5 of a mode-2 transfer.
        @(negedge clk);
        spi_mode = MODE2; spi_msb_first = 1'b1; spi_cs_sel = '0; spi_data_depth = 6'd16;
        spi_data_tx = 32'h0000_1234; use_loop = 1'b1; sl_depth = 16; sl_msb = 1'b1;
        sl_cpol = 1'b1; sl_cpha = 1'b0;
        @(negedge clk);
        rxv_cnt = 0; mosi_bits.delete();
        spi_start = 1'b1;
        @(negedge clk);
        spi_start = 1'b0;
        for (int i = 0; i < 500 && mosi_bits.size() < 5; i++) @(negedge clk);
        chk("abort_at_bit5", mosi_bits.size(), 5);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", spi_cs_n, 3'b111);
        chk("abort_sclk", spi_sclk, 0);
        chk("abort_ready", spi_ready, 1);
        chk("abort_mosi", spi_mosi, 0);
        chk("abort_rx_valid", spi_rx_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_no_rxv", rxv_cnt, 0);
        chk("abort_rx_cleared", spi_data_rx, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
